dbuffer_arbiter: RTL and testbench

//  Shares the single-port data-buffer SRAM (dbuffer_sram, 32-bit word, 1-cycle registered read) between
//  two requesters: m0 = core MEM-stage load/store port, m1 = DMA/debug port. Arbitrates with
//  m0 priority plus an m1 anti-starvation override. Performs byte-enable writes via read-modify-write.

---
 rtl/dbuffer_arbiter_pkg.sv | 22 ++
 rtl/dbuffer_arbiter_if.sv | 26 ++
 rtl/dbuffer_byte_merge.sv | 17 +
 rtl/dbuffer_sram.sv | 22 ++
 rtl/dbuffer_arbiter.sv | 145 ++++++++++++++
 tb/tb_dbuffer_arbiter.sv | 258 +++++++++++++++++++++++++
 6 files changed

// File: rtl/dbuffer_arbiter_pkg.sv
// Shared types and constants for the data-buffer arbiter.
// Holds SRAM geometry, FSM state encoding and byte-enable helpers.
package dbuffer_arbiter_pkg;

  localparam int DBUFFER_SRAM_ADDR_WIDTH = 10;
  localparam int DBUFFER_SRAM_DEPTH = 1 << DBUFFER_SRAM_ADDR_WIDTH;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic {
    DBA_IDLE = 1'b0,
    DBA_RMW  = 1'b1
  } dba_state_e;

  function automatic logic be_partial(
    input logic [3:0] be
  );
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/dbuffer_arbiter_if.sv
// Requester port bundle: request/grant handshake plus read return.
// master = requester side, slave = arbiter side.
interface dbuffer_arbiter_if #(
  parameter int ADDR_W = 10
) ();

  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dbuffer_byte_merge.sv
// Byte-lane merge for read-modify-write.
// Enabled lanes take new data, others keep the old word.
module dbuffer_byte_merge (
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dbuffer_sram.sv
// Single-port data-buffer SRAM, 32-bit words.
// Read data is registered: one cycle after a read access.
module dbuffer_sram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              csn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [31:0]       datain,
  output logic [31:0]       dataout
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (!csn && write_en) mem[addr] <= datain;
    if (!csn && read_en) dataout <= mem[addr];
  end

endmodule

// File: rtl/dbuffer_arbiter.sv
// Two-port arbiter in front of the data-buffer SRAM.
// m0 priority, m1 anti-starvation, byte writes via read-modify-write.
module dbuffer_arbiter
  import dbuffer_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DBUFFER_SRAM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dbuffer_arbiter_if.slave  m0_if,
  dbuffer_arbiter_if.slave  m1_if,
  output logic              buffer_csn,
  output logic [ADDR_W-1:0] buffer_addr,
  output logic              buffer_write_en,
  output logic              buffer_read_en,
  output logic [31:0]       buffer_datain,
  input  logic [31:0]       buffer_dataout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  dba_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [3:0]        rmw_be_q, rmw_be_d;
  logic [31:0]       rmw_wdata_q, rmw_wdata_d;

  logic              win_m1;
  logic              win_we;
  logic [3:0]        win_be;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic              sel0, sel1;
  logic              csn, wen, ren;
  logic [31:0]       merged;

  dbuffer_byte_merge u_merge (
    .be_i    (rmw_be_q),
    .wdata_i (rmw_wdata_q),
    .old_i   (buffer_dataout),
    .merged_o(merged)
  );

  assign win_m1 = m1_if.req &
    (!m0_if.req || starve_q == LIMIT);
  assign win_we    = win_m1 ? m1_if.we    : m0_if.we;
  assign win_be    = win_m1 ? m1_if.be    : m0_if.be;
  assign win_addr  = win_m1 ? m1_if.addr  : m0_if.addr;
  assign win_wdata = win_m1 ? m1_if.wdata : m0_if.wdata;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    rmw_addr_d  = rmw_addr_q;
    rmw_be_d    = rmw_be_q;
    rmw_wdata_d = rmw_wdata_q;
    sel0        = 1'b0;
    sel1        = 1'b0;
    csn         = 1'b1;
    wen         = 1'b0;
    ren         = 1'b0;
    buffer_addr   = win_addr;
    buffer_datain = win_wdata;
    unique case (state_q)
      DBA_IDLE: begin
        sel1 = win_m1;
        sel0 = m0_if.req & !win_m1;
        if (m1_if.req && !win_m1)
          starve_d = (starve_q == LIMIT) ?
            starve_q : starve_q + 4'd1;
        else
          starve_d = 4'd0;
        if (sel0 || sel1) begin
          unique case (1'b1)
            !win_we: begin
              csn   = 1'b0;
              ren   = 1'b1;
              rv0_d = sel0;
              rv1_d = sel1;
            end
            win_we && win_be == BE_FULL: begin
              csn = 1'b0;
              wen = 1'b1;
            end
            win_we && be_partial(win_be): begin
              // Fetch the old word now, merge next cycle
              csn         = 1'b0;
              ren         = 1'b1;
              rmw_addr_d  = win_addr;
              rmw_be_d    = win_be;
              rmw_wdata_d = win_wdata;
              state_d     = DBA_RMW;
            end
            default: ;
          endcase
        end
      end
      DBA_RMW: begin
        csn           = 1'b0;
        wen           = 1'b1;
        buffer_addr   = rmw_addr_q;
        buffer_datain = merged;
        state_d       = DBA_IDLE;
      end
    endcase
  end

  // Reset must silence the bus even though req is combinational
  assign m0_if.gnt       = sel0 & rst_n;
  assign m1_if.gnt       = sel1 & rst_n;
  assign buffer_csn      = csn | !rst_n;
  assign buffer_write_en = wen & rst_n;
  assign buffer_read_en  = ren & rst_n;

  assign m0_if.rvalid = rv0_q;
  assign m1_if.rvalid = rv1_q;
  assign m0_if.rdata  = buffer_dataout;
  assign m1_if.rdata  = buffer_dataout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DBA_IDLE;
      starve_q    <= 4'd0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= 4'd0;
      rmw_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
    end
  end

endmodule

// File: tb/tb_dbuffer_arbiter.sv
// Scoreboard bench for dbuffer_arbiter with the SRAM behind it.
// Reads push expected data/cycle; a negedge monitor pops on rvalid.
module tb_dbuffer_arbiter;
  import dbuffer_arbiter_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dbuffer_arbiter_if #(.ADDR_W(AW)) m0 ();
  dbuffer_arbiter_if #(.ADDR_W(AW)) m1 ();

  logic          buffer_csn;
  logic [AW-1:0] buffer_addr;
  logic          buffer_write_en;
  logic          buffer_read_en;
  logic [31:0]   buffer_datain;
  logic [31:0]   buffer_dataout;

  dbuffer_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_if          (m0),
    .m1_if          (m1),
    .buffer_csn     (buffer_csn),
    .buffer_addr    (buffer_addr),
    .buffer_write_en(buffer_write_en),
    .buffer_read_en (buffer_read_en),
    .buffer_datain  (buffer_datain),
    .buffer_dataout (buffer_dataout)
  );

  dbuffer_sram #(.ADDR_W(AW)) u_sram (
    .clk     (clk),
    .csn     (buffer_csn),
    .addr    (buffer_addr),
    .write_en(buffer_write_en),
    .read_en (buffer_read_en),
    .datain  (buffer_datain),
    .dataout (buffer_dataout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem [0:31];

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int g0[12];
  int g1[2];
  int ga, gb, gc, gd, base;

  function automatic void chk(string name,
    logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
        name, act, req);
    end
  endfunction

  task automatic drive(int p, bit we, logic [3:0] be,
    logic [AW-1:0] a, logic [31:0] wd, bit rq);
    if (p == 0) begin
      m0.req = rq; m0.we = we; m0.be = be;
      m0.addr = a; m0.wdata = wd;
    end else begin
      m1.req = rq; m1.we = we; m1.be = be;
      m1.addr = a; m1.wdata = wd;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the grant cycle
  task automatic issue(int p, bit we, logic [3:0] be,
    logic [AW-1:0] a, logic [31:0] wd, logic [31:0] ex,
    output int gcyc);
    bit   g;
    exp_t e;
    g = 1'b0;
    gcyc = -1;
    drive(p, we, be, a, wd, 1'b1);
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      if ((p == 0 ? m0.gnt : m1.gnt) === 1'b1) begin
        g = 1'b1;
        gcyc = cyc;
        if (!we) begin
          e.d = ex;
          e.c = cyc + 1;
          if (p == 0) q0.push_back(e);
          else q1.push_back(e);
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[4:0]][8*b +: 8] = wd[8*b +: 8];
        end
      end
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    if (!g) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout port=%0d actual=no_gnt required=gnt", p);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (m0.rvalid === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL m0_rvalid_unexpected actual=1 required=0");
        end else begin
          e = q0.pop_front();
          chk("m0_rdata", m0.rdata, e.d);
          chk("m0_rvalid_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (m1.rvalid === 1'b1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL m1_rvalid_unexpected actual=1 required=0");
        end else begin
          e = q1.pop_front();
          chk("m1_rdata", m1.rdata, e.d);
          chk("m1_rvalid_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (m0.req && m1.req)
        chk("single_gnt", 32'(m0.gnt & m1.gnt), 32'd0);
      if (buffer_read_en || buffer_write_en)
        chk("en_exclusive",
          32'(buffer_read_en & buffer_write_en), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b1, 4'hF, 10'd20, 32'hA5A5_0000, 1'b1);
    drive(1, 1'b1, 4'hF, 10'd21, 32'h5A5A_1111, 1'b1);
    // 1: reset holds everything quiet
    @(negedge clk);
    chk("rst_gnt0", 32'(m0.gnt), 32'd0);
    chk("rst_gnt1", 32'(m1.gnt), 32'd0);
    chk("rst_csn", 32'(buffer_csn), 32'd1);
    chk("rst_wen", 32'(buffer_write_en), 32'd0);
    chk("rst_ren", 32'(buffer_read_en), 32'd0);
    chk("rst_rv0", 32'(m0.rvalid), 32'd0);
    chk("rst_rv1", 32'(m1.rvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_gnt0", 32'(m0.gnt), 32'd1);
    chk("rel_gnt1", 32'(m1.gnt), 32'd0);
    ref_mem[20] = 32'hA5A5_0000;
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    issue(1, 1'b1, 4'hF, 10'd21, 32'h5A5A_1111, 32'h0, ga);
    issue(0, 1'b0, 4'h0, 10'd20, 32'h0, 32'hA5A5_0000, ga);
    issue(1, 1'b0, 4'h0, 10'd21, 32'h0, 32'h5A5A_1111, ga);

    // 2: full write then read next cycle
    issue(0, 1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF, 32'h0, ga);
    issue(0, 1'b0, 4'h0, 10'd5, 32'h0, 32'hDEAD_BEEF, gb);
    chk("t2_b2b_gnt", 32'(gb), 32'(ga + 1));

    // 3: partial write by m1, m0 blocked in RMW cycle
    issue(0, 1'b1, 4'hF, 10'd9, 32'h1122_3344, 32'h0, ga);
    issue(1, 1'b1, 4'b0101, 10'd9, 32'hAABB_CCDD, 32'h0, ga);
    drive(0, 1'b0, 4'h0, 10'd9, 32'h0, 1'b1);
    @(negedge clk);
    chk("rmw_gnt0", 32'(m0.gnt), 32'd0);
    chk("rmw_wen", 32'(buffer_write_en), 32'd1);
    chk("rmw_csn", 32'(buffer_csn), 32'd0);
    chk("rmw_datain", buffer_datain, 32'h11BB_33DD);
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h0, 10'd9, 32'h0, 32'h11BB_33DD, gb);
    chk("t3_rmw_occupancy", 32'(gb), 32'(ga + 2));

    // be=0 write: granted with no SRAM access
    drive(0, 1'b1, 4'h0, 10'd9, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("be0_gnt", 32'(m0.gnt), 32'd1);
    chk("be0_csn", 32'(buffer_csn), 32'd1);
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h0, 10'd9, 32'h0, 32'h11BB_33DD, ga);

    // 6: fill 0..7 then stream reads one per cycle
    for (int i = 0; i < 8; i++)
      issue(0, 1'b1, 4'hF, AW'(i),
        32'h1000_0000 + 32'(i) * 32'h0101, 32'h0, ga);
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, 4'h0, AW'(i), 32'h0, ref_mem[i], ga);
      if (i == 0) base = ga;
      else chk("stream_gnt", 32'(ga), 32'(base + i));
    end

    // 4: continuous contention, m1 wins every fifth cycle
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          issue(0, 1'b0, 4'h0, AW'(k % 8), 32'h0,
            ref_mem[k % 8], gc);
          g0[k] = gc;
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          issue(1, 1'b0, 4'h0, AW'(k + 2), 32'h0,
            ref_mem[k + 2], gd);
          g1[k] = gd;
        end
      end
    join
    for (int k = 1; k < 12; k++)
      chk("starve_m0_gnt", 32'(g0[k]),
        32'(g0[0] + (k < 4 ? k : (k < 8 ? k + 1 : k + 2))));
    chk("starve_m1_first", 32'(g1[0]), 32'(g0[0] + 4));
    chk("starve_m1_second", 32'(g1[1]), 32'(g0[0] + 9));

    // 5: reset during RMW drops the write
    issue(0, 1'b1, 4'hF, 10'd3, 32'h0, 32'h0, ga);
    issue(1, 1'b1, 4'b0001, 10'd3, 32'h0000_00FF, 32'h0, ga);
    ref_mem[3] = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrmw_wen", 32'(buffer_write_en), 32'd0);
    chk("rstrmw_csn", 32'(buffer_csn), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 1'b0, 4'h0, 10'd3, 32'h0, 32'h0000_0000, ga);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
